// File: rtl/phv_seg_tx.sv
// Serialises one PHV into SEG_NUM contiguous SEG_WIDTH-bit beats with valid/ready/last framing.
// Optional statistics counters (phv_tx_cnt, stall_cnt) are built when PHV_SEG_TX_STATS_EN is defined.
module phv_seg_tx #(
  parameter int unsigned PKT_VEC_WIDTH = 1124,
  parameter int unsigned SEG_WIDTH     = 512
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic [PKT_VEC_WIDTH-1:0] phv_in,
  input  logic                     phv_in_valid,
  output logic                     phv_in_ready,
  output logic [SEG_WIDTH-1:0]     seg_tdata,
  output logic                     seg_tvalid,
  input  logic                     seg_tready,
  output logic                     seg_tlast,
`ifdef PHV_SEG_TX_STATS_EN
  output logic [31:0]              phv_tx_cnt,
  output logic [31:0]              stall_cnt,
`endif
  output logic [1:0]               seg_tidx
);

  localparam int unsigned SEG_NUM = (PKT_VEC_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int unsigned BufW    = SEG_NUM * SEG_WIDTH;
  localparam logic [1:0]  LastIdx = 2'(SEG_NUM - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e                            state_q;
  logic [1:0]                        seg_cnt_q;
  logic [SEG_NUM-1:0][SEG_WIDTH-1:0] buf_q;
  logic [BufW-1:0]                   load_data;
  logic                              beat_acc;
  logic                              last_acc;
  logic                              load;

  // Bits above the PHV are zero so the final beat carries clean padding.
  always_comb begin
    load_data = '0;
    load_data[PKT_VEC_WIDTH-1:0] = phv_in;
  end

  // Outputs come straight from flops, so tvalid never depends on tready.
  assign seg_tvalid   = (state_q == StSend);
  assign seg_tlast    = seg_tvalid & (seg_cnt_q == LastIdx);
  assign seg_tidx     = seg_cnt_q;
  assign seg_tdata    = buf_q[seg_cnt_q];
  assign beat_acc     = seg_tvalid & seg_tready;
  assign last_acc     = beat_acc & seg_tlast;
  assign phv_in_ready = (state_q == StIdle) | last_acc;
  assign load         = phv_in_valid & phv_in_ready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q   <= StIdle;
      seg_cnt_q <= '0;
      buf_q     <= '0;
    end else begin
      if (load) begin
        buf_q <= load_data;
      end
      unique case (state_q)
        StIdle: begin
          if (phv_in_valid) begin
            state_q   <= StSend;
            seg_cnt_q <= '0;
          end
        end
        StSend: begin
          if (beat_acc) begin
            if (seg_tlast) begin
              // Next PHV loads on the same edge as the last beat: no bubble.
              seg_cnt_q <= '0;
              if (!phv_in_valid) begin
                state_q <= StIdle;
              end
            end else begin
              seg_cnt_q <= seg_cnt_q + 2'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef PHV_SEG_TX_STATS_EN
  logic [31:0] phv_tx_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      phv_tx_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (last_acc) begin
        phv_tx_cnt_q <= phv_tx_cnt_q + 32'd1;
      end
      if (seg_tvalid & ~seg_tready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign phv_tx_cnt = phv_tx_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_phv_seg_tx.sv
// Bench for phv_seg_tx: directed cycle table, back-to-back, mid-PHV reset and a random soak
// against a queue-based reassembly model. Stats checks are built with PHV_SEG_TX_STATS_EN.
module tb_phv_seg_tx;
  localparam int unsigned PW = 1124;
  localparam int unsigned SW = 512;
  localparam int unsigned NB = 3;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic [PW-1:0] phv_in = '0;
  logic          phv_in_valid = 1'b0;
  logic          phv_in_ready;
  logic [SW-1:0] seg_tdata;
  logic          seg_tvalid;
  logic          seg_tready = 1'b0;
  logic          seg_tlast;
  logic [1:0]    seg_tidx;
`ifdef PHV_SEG_TX_STATS_EN
  logic [31:0]   phv_tx_cnt;
  logic [31:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int exp_tx = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  phv_seg_tx dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .phv_in       (phv_in),
    .phv_in_valid (phv_in_valid),
    .phv_in_ready (phv_in_ready),
    .seg_tdata    (seg_tdata),
    .seg_tvalid   (seg_tvalid),
    .seg_tready   (seg_tready),
    .seg_tlast    (seg_tlast),
`ifdef PHV_SEG_TX_STATS_EN
    .phv_tx_cnt   (phv_tx_cnt),
    .stall_cnt    (stall_cnt),
`endif
    .seg_tidx     (seg_tidx)
  );

  task automatic checkw(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] rand_phv();
    logic [1151:0] w;
    for (int i = 0; i < 36; i++) w[i*32 +: 32] = $urandom();
    return w[PW-1:0];
  endfunction

  // Beat k of a PHV: the zero-extended vector shifted down by k beats.
  function automatic logic [SW-1:0] beat_of(input logic [PW-1:0] p, input int k);
    logic [NB*SW-1:0] w;
    w = (NB*SW)'(p) >> (k * SW);
    return w[SW-1:0];
  endfunction

  task automatic check_stats(input string name);
`ifdef PHV_SEG_TX_STATS_EN
    checki({name, "_tx_cnt"}, int'(phv_tx_cnt), exp_tx);
    checki({name, "_stall_cnt"}, int'(stall_cnt), exp_stall);
`else
    n_cmp = n_cmp + 0;
    if (name.len() == 0) $display("stats %s", name);
`endif
  endtask

  typedef struct {
    int in_valid;
    int tready;
    int drv;
    int e_valid;
    int e_idx;
    int e_last;
    int e_ready;
    int e_p;
  } vec_t;

  vec_t tbl[19];
  logic [PW-1:0] phv_tbl[3];

  function automatic vec_t mk(input int iv, input int tr, input int dv, input int ev,
                              input int ei, input int el, input int er, input int ep);
    vec_t v;
    v.in_valid = iv; v.tready = tr; v.drv = dv; v.e_valid = ev;
    v.e_idx = ei; v.e_last = el; v.e_ready = er; v.e_p = ep;
    return v;
  endfunction

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] b2b[4];
    logic [PW-1:0] x_phv, y_phv, cur;
    logic [PW-1:0] sent_q[$];
    logic [NB*SW-1:0] rx;
    logic [SW-1:0] prev_data;
    logic [1:0] prev_idx;
    logic prev_last, prev_stall, holding, exp_rdy;
    int loaded, rx_idx, n_sent, n_done, cyc;

    phv_tbl[0] = {100'hA, 512'hB, 512'hC};
    phv_tbl[1] = rand_phv();
    phv_tbl[2] = rand_phv();
    //              iv tr dv  ev ei el er ep
    tbl[0]  = mk(1, 1, 0,  0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 1, 0,  1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0,  1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0,  1, 2, 1, 1, 0);
    tbl[4]  = mk(0, 1, 0,  0, 0, 0, 1, 0);
    tbl[5]  = mk(1, 0, 1,  0, 0, 0, 1, 1);
    tbl[6]  = mk(0, 1, 1,  1, 0, 0, 0, 1);
    for (int i = 7; i < 12; i++) tbl[i] = mk(0, 0, 1, 1, 1, 0, 0, 1);
    tbl[12] = mk(0, 1, 1,  1, 1, 0, 0, 1);
    tbl[13] = mk(1, 0, 2,  1, 2, 1, 0, 1);
    tbl[14] = mk(1, 1, 2,  1, 2, 1, 1, 1);
    tbl[15] = mk(0, 1, 2,  1, 0, 0, 0, 2);
    tbl[16] = mk(0, 1, 2,  1, 1, 0, 0, 2);
    tbl[17] = mk(0, 1, 2,  1, 2, 1, 1, 2);
    tbl[18] = mk(0, 1, 2,  0, 0, 0, 1, 2);

    // Reset values on the first cycle after reset deasserts.
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(negedge clk);
    checki("rst_tvalid", int'(seg_tvalid), 0);
    checki("rst_tlast", int'(seg_tlast), 0);
    checki("rst_tidx", int'(seg_tidx), 0);
    checki("rst_ready", int'(phv_in_ready), 1);
    checkw("rst_tdata", seg_tdata, '0);
    check_stats("rst");
    next_cycle();

    // Directed table: single PHV, back-pressure on beat 1 and on the last beat.
    for (int i = 0; i < 19; i++) begin
      phv_in_valid = (tbl[i].in_valid != 0);
      seg_tready   = (tbl[i].tready != 0);
      phv_in       = phv_tbl[tbl[i].drv];
      @(negedge clk);
      checki($sformatf("tbl%0d_tvalid", i), int'(seg_tvalid), tbl[i].e_valid);
      checki($sformatf("tbl%0d_ready", i), int'(phv_in_ready), tbl[i].e_ready);
      if (tbl[i].e_valid != 0) begin
        checki($sformatf("tbl%0d_tidx", i), int'(seg_tidx), tbl[i].e_idx);
        checki($sformatf("tbl%0d_tlast", i), int'(seg_tlast), tbl[i].e_last);
        checkw($sformatf("tbl%0d_tdata", i), seg_tdata,
               beat_of(phv_tbl[tbl[i].e_p], tbl[i].e_idx));
        if (tbl[i].tready == 0) exp_stall++;
        else if (tbl[i].e_last != 0) exp_tx++;
      end
      next_cycle();
    end
    check_stats("tbl");

    // Back-to-back: four PHVs stream as twelve gapless beats.
    for (int i = 0; i < 4; i++) b2b[i] = rand_phv();
    loaded = 0;
    for (int c = 0; c < 14; c++) begin
      phv_in_valid = (loaded < 4);
      phv_in       = b2b[(loaded < 4) ? loaded : 3];
      seg_tready   = 1'b1;
      @(negedge clk);
      if (c == 0 || c == 13) begin
        checki($sformatf("b2b%0d_tvalid", c), int'(seg_tvalid), 0);
        checki($sformatf("b2b%0d_ready", c), int'(phv_in_ready), 1);
      end else begin
        checki($sformatf("b2b%0d_tvalid", c), int'(seg_tvalid), 1);
        checki($sformatf("b2b%0d_tidx", c), int'(seg_tidx), (c - 1) % 3);
        checki($sformatf("b2b%0d_ready", c), int'(phv_in_ready), ((c - 1) % 3 == 2) ? 1 : 0);
        checkw($sformatf("b2b%0d_tdata", c), seg_tdata, beat_of(b2b[(c - 1) / 3], (c - 1) % 3));
        if ((c - 1) % 3 == 2) exp_tx++;
      end
      if (phv_in_valid && (c == 0 || (c - 1) % 3 == 2)) loaded++;
      next_cycle();
    end
    phv_in_valid = 1'b0;
    check_stats("b2b");

    // Reset one cycle after beat 0 of a PHV is accepted.
    x_phv = rand_phv();
    y_phv = rand_phv();
    phv_in = x_phv;
    phv_in_valid = 1'b1;
    seg_tready = 1'b1;
    next_cycle();
    phv_in_valid = 1'b0;
    @(negedge clk);
    checkw("mrst_beat0", seg_tdata, beat_of(x_phv, 0));
    next_cycle();
    aresetn = 1'b0;
    seg_tready = 1'b0;
    next_cycle();
    aresetn = 1'b1;
    exp_tx = 0;
    exp_stall = 0;
    @(negedge clk);
    checki("mrst_tvalid", int'(seg_tvalid), 0);
    checki("mrst_tidx", int'(seg_tidx), 0);
    checki("mrst_ready", int'(phv_in_ready), 1);
    check_stats("mrst");
    phv_in = y_phv;
    phv_in_valid = 1'b1;
    seg_tready = 1'b1;
    next_cycle();
    phv_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checki($sformatf("mrst_y%0d_tidx", k), int'(seg_tidx), k);
      checkw($sformatf("mrst_y%0d_tdata", k), seg_tdata, beat_of(y_phv, k));
      next_cycle();
    end
    exp_tx++;
    @(negedge clk);
    checki("mrst_end_tvalid", int'(seg_tvalid), 0);
    next_cycle();

    // Random soak: reassembled PHVs must equal the accepted sequence, in order.
    rx = '0; rx_idx = 0; n_sent = 0; n_done = 0; cyc = 0;
    holding = 1'b0; prev_stall = 1'b0; cur = '0;
    prev_data = '0; prev_idx = '0; prev_last = 1'b0;
    while (n_done < 1000 && cyc < 40000) begin
      if (!holding && n_sent < 1000 && $urandom_range(0, 3) != 0) begin
        cur = rand_phv();
        holding = 1'b1;
      end
      phv_in       = cur;
      phv_in_valid = holding && ($urandom_range(0, 9) != 0);
      seg_tready   = ($urandom_range(0, 1) != 0);
      @(negedge clk);
      if (prev_stall) begin
        checki("soak_hold_tvalid", int'(seg_tvalid), 1);
        checkw("soak_hold_tdata", seg_tdata, prev_data);
        checki("soak_hold_tidx", int'(seg_tidx), int'(prev_idx));
        checki("soak_hold_tlast", int'(seg_tlast), int'(prev_last));
      end
      checki("soak_tvalid", int'(seg_tvalid), (sent_q.size() != 0) ? 1 : 0);
      exp_rdy = (sent_q.size() == 0) || (seg_tready && rx_idx == NB - 1);
      checki("soak_ready", int'(phv_in_ready), int'(exp_rdy));
      if (seg_tvalid && sent_q.size() != 0) begin
        checki("soak_tidx", int'(seg_tidx), rx_idx);
        checki("soak_tlast", int'(seg_tlast), (rx_idx == NB - 1) ? 1 : 0);
        if (!seg_tready) exp_stall++;
        else begin
          rx[rx_idx*SW +: SW] = seg_tdata;
          if (rx_idx == NB - 1) begin
            for (int k = 0; k < 3; k++)
              checkw($sformatf("soak_phv%0d_seg%0d", n_done, k), rx[k*SW +: SW],
                     beat_of(sent_q[0], k));
            void'(sent_q.pop_front());
            n_done++;
            exp_tx++;
            rx_idx = 0;
          end else rx_idx++;
        end
      end
      if (phv_in_valid && phv_in_ready) begin
        sent_q.push_back(cur);
        holding = 1'b0;
        n_sent++;
      end
      prev_stall = seg_tvalid && !seg_tready;
      prev_data = seg_tdata;
      prev_idx = seg_tidx;
      prev_last = seg_tlast;
      next_cycle();
      cyc++;
    end
    phv_in_valid = 1'b0;
    checki("soak_done", n_done, 1000);
    check_stats("soak");

`ifdef PHV_SEG_TX_STATS_EN
    // Counter wrap: preset to all-ones, one more PHV brings it to zero.
    seg_tready = 1'b1;
    force dut.phv_tx_cnt_q = 32'hFFFF_FFFF;
    next_cycle();
    release dut.phv_tx_cnt_q;
    phv_in = rand_phv();
    phv_in_valid = 1'b1;
    next_cycle();
    phv_in_valid = 1'b0;
    repeat (4) next_cycle();
    @(negedge clk);
    checki("wrap_tx_cnt", int'(phv_tx_cnt), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/phv_seg_tx.md
# phv_seg_tx

Transmit-side serializer for the segmented PHV link. Accepts one full 1124-bit packet header vector (PHV) from a stage output and emits it as SEG_NUM back-to-back SEG_WIDTH-bit beats with valid/ready/last framing. The matching receiver reassembles the beats into a PHV before the PHV FIFO halves. The block sits between the last match-action stage and the segment link, and sustains one PHV every SEG_NUM cycles with no bubbles.

## Interface
- PKT_VEC_WIDTH, 1124, PHV width in bits
- SEG_WIDTH, 512, beat width in bits
- SEG_NUM, (PKT_VEC_WIDTH+SEG_WIDTH-1)/SEG_WIDTH (=3), beats per PHV; derived, not overridden
- clk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- phv_in  in  PKT_VEC_WIDTH  PHV to send; sampled when phv_in_valid & phv_in_ready
- phv_in_valid  in  1  PHV present
- phv_in_ready  out  1  block can take a PHV this cycle (combinational)
- seg_tdata  out  SEG_WIDTH  current beat
- seg_tvalid  out  1  beat valid
- seg_tready  in  1  downstream accepts beat
- seg_tlast  out  1  final beat of a PHV
- seg_tidx  out  2  beat index 0..SEG_NUM-1
- phv_tx_cnt  out  32  PHVs fully sent (only with PHV_SEG_TX_STATS_EN)
- stall_cnt  out  32  cycles with seg_tvalid & ~seg_tready (only with PHV_SEG_TX_STATS_EN)

## Operation
- Holding register buf[SEG_NUM*SEG_WIDTH-1:0]. Bits above PKT_VEC_WIDTH are zero-padded on load.
- State machine IDLE/SEND; beat counter seg_cnt (2 bits).
- IDLE: seg_tvalid=0. On phv_in_valid, load buf, seg_cnt<=0, go to SEND.
- SEND:
  - seg_tdata=buf[seg_cnt*SEG_WIDTH +: SEG_WIDTH], seg_tidx=seg_cnt, seg_tlast=(seg_cnt==SEG_NUM-1).
  - A beat is accepted when seg_tvalid & seg_tready. A non-last accept increments seg_cnt.
  - When the last beat is accepted: if phv_in_valid, load the new PHV, set seg_cnt<=0 and stay in SEND. Otherwise go to IDLE.
- phv_in_ready = (state==IDLE) | (seg_tvalid & seg_tready & seg_tlast).
- PHVs are never dropped, reordered or interleaved. Beats of one PHV are always contiguous on the link.
- Handshake rules:
  - While seg_tvalid & ~seg_tready, seg_tdata/seg_tlast/seg_tidx stay stable and seg_tvalid stays high.
  - seg_tvalid does not depend combinationally on seg_tready.
  - phv_in_valid may drop without a handshake; the source holds phv_in until ready.
- Beat 0 carries PHV bits [511:0], beat 1 carries [1023:512], beat 2 carries {412'b0, [1123:1024]}.

## Timing
- Reset values: state=IDLE, seg_cnt=0, seg_tvalid=0, seg_tlast=0, seg_tidx=0, seg_tdata=0, buf=0, counters=0. phv_in_ready=1 the first cycle after reset deasserts.
- Latency: PHV accepted at edge N; beat 0 valid from cycle N+1.
- Throughput: with seg_tready=1 and a continuous phv_in_valid, beats stream every cycle. The next PHV loads on the same edge as the previous last beat, so there is no idle cycle.
- Reset mid-PHV: the partial PHV is abandoned and seg_tvalid=0 next cycle. The receiver relies on its own reset; no completion beats are sent.
- Back-pressure on the last beat holds phv_in_ready low until that beat is accepted.

## Configuration
- PHV_SEG_TX_STATS_EN defined:
  - phv_tx_cnt increments on each accepted last beat.
  - stall_cnt increments each cycle with seg_tvalid & ~seg_tready.
  - Both are 32-bit, wrap 0xFFFFFFFF→0, and reset to 0.
- PHV_SEG_TX_STATS_EN undefined: both ports and their counters are absent. Datapath behaviour is identical.

## Test plan
- Single PHV, seg_tready=1, phv_in = {100'hA, 512'hB, 512'hC}:
  - beats C, B, {412'b0,100'hA} on cycles N+1..N+3, seg_tidx 0,1,2, seg_tlast only on idx 2.
  - seg_tvalid=0 at N+4.
- Back-to-back PHVs, 4 PHVs with continuous phv_in_valid and seg_tready=1:
  - 12 consecutive valid beats with no gap.
  - phv_in_ready high only in IDLE and on last-beat cycles.
  - With STATS_EN: phv_tx_cnt=4.
- Back-pressure, seg_tready low for 5 cycles during beat 1:
  - beat 1 data/tidx stable for all 5 cycles, phv_in_ready=0 throughout.
  - With STATS_EN: stall_cnt=5.
- Reset mid-PHV, aresetn=0 for one cycle after beat 0 is accepted:
  - seg_tvalid=0, seg_tidx=0 next cycle.
  - The next PHV starts at beat 0 with correct data.
- Random-stall soak: 1000 random PHVs, random seg_tready (50%) and random phv_in_valid gaps. The reassembled PHVs match the input sequence exactly, in order.
- Counter wrap (STATS_EN): force phv_tx_cnt to 0xFFFFFFFF and send one PHV; the counter reads 0.
